// File: rtl/spmm_job_sequencer_if.sv
// Host/buffer handshake bundle for the SpMM job sequencer.
// The host (master) drives the start and mode inputs, and the sequencer (slave) drives the rest.
interface spmm_job_sequencer_if #(
    parameter int unsigned N = 16
);
    localparam int unsigned BW = ($clog2(N) > 2) ? $clog2(N) - 2 : 1;
    localparam int unsigned RW = $clog2(N);

    logic          rhs_start;
    logic          lhs_start;
    logic          lhs_ws;
    logic          lhs_os;
    logic          out_start;
    logic          rhs_ready;
    logic          lhs_ready_ns;
    logic          lhs_ready_ws;
    logic          lhs_ready_os;
    logic          lhs_ready_wos;
    logic          out_ready;
    logic          rhs_wr_en;
    logic [BW-1:0] rhs_wr_blk;
    logic          lhs_issue;
    logic [RW-1:0] lhs_row;
    logic          acc_wr_en;
    logic [RW-1:0] acc_row;
    logic          acc_accum;
    logic          out_rd_en;
    logic [BW-1:0] out_rd_blk;
    logic          busy;

    modport master (
        output rhs_start, lhs_start, lhs_ws, lhs_os, out_start,
        input  rhs_ready, lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos, out_ready,
        input  rhs_wr_en, rhs_wr_blk, lhs_issue, lhs_row, acc_wr_en, acc_row, acc_accum,
        input  out_rd_en, out_rd_blk, busy
    );

    modport slave (
        input  rhs_start, lhs_start, lhs_ws, lhs_os, out_start,
        output rhs_ready, lhs_ready_ns, lhs_ready_ws, lhs_ready_os, lhs_ready_wos, out_ready,
        output rhs_wr_en, rhs_wr_blk, lhs_issue, lhs_row, acc_wr_en, acc_row, acc_accum,
        output out_rd_en, out_rd_blk, busy
    );
endinterface

// File: rtl/spmm_job_sequencer.sv
// Job controller for the SpMM engine: RHS load, LHS row streaming, PE drain, result hold
// and output drain, with weight-stationary and output-stationary job chaining.
module spmm_job_sequencer #(
    parameter int unsigned N        = 16,
    parameter int unsigned DELAY_PE = $clog2(N) + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    spmm_job_sequencer_if.slave   bus
);
    localparam int unsigned BW = ($clog2(N) > 2) ? $clog2(N) - 2 : 1;
    localparam int unsigned RW = $clog2(N);
    localparam logic [RW-1:0] LastBlk = RW'(N / 4 - 1);
    localparam logic [RW-1:0] LastRow = RW'(N - 1);

    typedef enum logic [2:0] {
        StIdle, StLoadRhs, StWaitLhs, StStream, StDrain, StHold, StSendOut
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic          keep_q, keep_d;
    logic          os_q, os_d;
    logic [DELAY_PE-1:0] vld_q, vld_d;
    logic [RW-1:0] row_q [DELAY_PE];
    logic [RW-1:0] row_d [DELAY_PE];

    logic          rdy_rhs, rdy_ns, rdy_ws, rdy_os, rdy_wos, rdy_out;
    logic          lhs_ok;
    logic          wr_en, issue, rd_en;
    logic [BW-1:0] wr_blk, rd_blk;
    logic [RW-1:0] row;

    assign rdy_rhs = (state_q == StIdle);
    assign rdy_ns  = (state_q == StWaitLhs);
    assign rdy_ws  = (state_q == StWaitLhs);
    assign rdy_out = (state_q == StHold);
    assign rdy_os  = (state_q == StHold) && keep_q;
    assign rdy_wos = (state_q == StHold) && keep_q;

    // A start is honoured only when the ready for its own {ws,os} mode is up.
    always_comb begin
        unique case ({bus.lhs_ws, bus.lhs_os})
            2'b00:   lhs_ok = bus.lhs_start && rdy_ns;
            2'b10:   lhs_ok = bus.lhs_start && rdy_ws;
            2'b01:   lhs_ok = bus.lhs_start && rdy_os;
            default: lhs_ok = bus.lhs_start && rdy_wos;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        keep_d  = keep_q;
        os_d    = os_q;
        wr_en   = 1'b0;
        wr_blk  = '0;
        issue   = 1'b0;
        row     = '0;
        rd_en   = 1'b0;
        rd_blk  = '0;
        case (state_q)
            StIdle: begin
                if (bus.rhs_start) begin
                    wr_en   = 1'b1;
                    state_d = (N > 4) ? StLoadRhs : StWaitLhs;
                    cnt_d   = (N > 4) ? RW'(1) : '0;
                end
            end
            StLoadRhs: begin
                wr_en  = 1'b1;
                wr_blk = cnt_q[BW-1:0];
                if (cnt_q == LastBlk) begin
                    state_d = StWaitLhs;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            StWaitLhs: begin
                if (lhs_ok) begin
                    issue   = 1'b1;
                    keep_d  = bus.lhs_ws;
                    os_d    = bus.lhs_os;
                    state_d = StStream;
                    cnt_d   = RW'(1);
                end
            end
            StStream: begin
                issue = 1'b1;
                row   = cnt_q;
                if (cnt_q == LastRow) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            StDrain: begin
                if (vld_q[DELAY_PE-1] && (row_q[DELAY_PE-1] == LastRow)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                // Output drain has priority over chaining another accumulate job.
                if (bus.out_start) begin
                    rd_en = 1'b1;
                    if (N > 4) begin
                        state_d = StSendOut;
                        cnt_d   = RW'(1);
                    end else begin
                        state_d = keep_q ? StWaitLhs : StIdle;
                        cnt_d   = '0;
                    end
                end else if (lhs_ok) begin
                    issue   = 1'b1;
                    keep_d  = bus.lhs_ws;
                    os_d    = bus.lhs_os;
                    state_d = StStream;
                    cnt_d   = RW'(1);
                end
            end
            StSendOut: begin
                rd_en  = 1'b1;
                rd_blk = cnt_q[BW-1:0];
                if (cnt_q == LastBlk) begin
                    state_d = keep_q ? StWaitLhs : StIdle;
                    keep_d  = keep_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Issue/row delay line models the PE array latency to the accumulator.
    always_comb begin
        vld_d[0] = issue;
        row_d[0] = row;
        for (int unsigned i = 1; i < DELAY_PE; i++) begin
            vld_d[i] = vld_q[i-1];
            row_d[i] = row_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            keep_q  <= 1'b0;
            os_q    <= 1'b0;
            vld_q   <= '0;
            row_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
            os_q    <= os_d;
            vld_q   <= vld_d;
            row_q   <= row_d;
        end
    end

    assign bus.rhs_ready     = ~reset & rdy_rhs;
    assign bus.lhs_ready_ns  = ~reset & rdy_ns;
    assign bus.lhs_ready_ws  = ~reset & rdy_ws;
    assign bus.lhs_ready_os  = ~reset & rdy_os;
    assign bus.lhs_ready_wos = ~reset & rdy_wos;
    assign bus.out_ready     = ~reset & rdy_out;
    assign bus.rhs_wr_en     = ~reset & wr_en;
    assign bus.rhs_wr_blk    = reset ? '0 : wr_blk;
    assign bus.lhs_issue     = ~reset & issue;
    assign bus.lhs_row       = reset ? '0 : row;
    assign bus.acc_wr_en     = ~reset & vld_q[DELAY_PE-1];
    assign bus.acc_row       = reset ? '0 : row_q[DELAY_PE-1];
    assign bus.acc_accum     = ~reset & os_q;
    assign bus.out_rd_en     = ~reset & rd_en;
    assign bus.out_rd_blk    = reset ? '0 : rd_blk;
    assign bus.busy          = ~reset & (state_q != StIdle);
endmodule

// File: tb/tb_spmm_job_sequencer.sv
// Scoreboard bench for spmm_job_sequencer (N=16, DELAY_PE=6): stimulus queues expected strobe
// events with their cycle numbers; a negedge monitor pops and compares every strobe it sees.
module tb_spmm_job_sequencer;
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    exp_t rhs_q[$], iss_q[$], acc_q[$], rd_q[$];

    spmm_job_sequencer_if #(.N(16)) bus ();

    spmm_job_sequencer #(.N(16)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] all_outs;
    assign all_outs = {bus.rhs_ready, bus.lhs_ready_ns, bus.lhs_ready_ws, bus.lhs_ready_os,
                       bus.lhs_ready_wos, bus.out_ready, bus.rhs_wr_en, bus.rhs_wr_blk,
                       bus.lhs_issue, bus.lhs_row, bus.acc_wr_en, bus.acc_row, bus.acc_accum,
                       bus.out_rd_en, bus.out_rd_blk, bus.busy};

    function automatic exp_t mk(int c, int v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic ev_check(string name, exp_t e, int act);
        checks++;
        if (e.cyc != cyc || e.val != act) begin
            errors++;
            $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
                     name, cyc, act, e.cyc, e.val);
        end
    endtask

    // Monitor: every strobe must match the head of its scoreboard queue.
    always @(negedge clk) begin
        exp_t none;
        none = mk(-1, -1);
        if (mon_on && !reset) begin
            if (bus.rhs_wr_en)
                ev_check("rhs_wr", (rhs_q.size() > 0) ? rhs_q.pop_front() : none,
                         int'(bus.rhs_wr_blk));
            if (bus.lhs_issue)
                ev_check("lhs_issue", (iss_q.size() > 0) ? iss_q.pop_front() : none,
                         int'(bus.lhs_row));
            if (bus.acc_wr_en)
                ev_check("acc_wr", (acc_q.size() > 0) ? acc_q.pop_front() : none,
                         int'(bus.acc_row) * 2 + int'(bus.acc_accum));
            if (bus.out_rd_en)
                ev_check("out_rd", (rd_q.size() > 0) ? rd_q.pop_front() : none,
                         int'(bus.out_rd_blk));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic drive(int c, bit rs, bit ls, bit ws, bit os, bit ost);
        go_to(c);
        bus.rhs_start = rs;
        bus.lhs_start = ls;
        bus.lhs_ws    = ws;
        bus.lhs_os    = os;
        bus.out_start = ost;
        tick();
        bus.rhs_start = 1'b0;
        bus.lhs_start = 1'b0;
        bus.lhs_ws    = 1'b0;
        bus.lhs_os    = 1'b0;
        bus.out_start = 1'b0;
    endtask

    task automatic at_neg(int c);
        go_to(c);
        @(negedge clk);
    endtask

    task automatic push_blks(bit rd, int c);
        for (int i = 0; i < 4; i++) begin
            if (rd) rd_q.push_back(mk(c + i, i));
            else    rhs_q.push_back(mk(c + i, i));
        end
    endtask

    // Rows issue from cycle c; accumulator writes follow 6 cycles later.
    task automatic push_job(int c, int n_iss, int n_acc, int accum);
        for (int i = 0; i < n_iss; i++) iss_q.push_back(mk(c + i, i));
        for (int i = 0; i < n_acc; i++) acc_q.push_back(mk(c + 6 + i, i * 2 + accum));
    endtask

    initial begin
        int t, s, r;
        bus.rhs_start = 1'b1;
        bus.lhs_start = 1'b1;
        bus.lhs_ws    = 1'b1;
        bus.lhs_os    = 1'b1;
        bus.out_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("reset_outputs_zero", int'(all_outs), 0);
        end
        tick();
        reset = 1'b0;
        bus.rhs_start = 1'b0;
        bus.lhs_start = 1'b0;
        bus.lhs_ws    = 1'b0;
        bus.lhs_os    = 1'b0;
        bus.out_start = 1'b0;
        mon_on = 1'b1;
        @(negedge clk);
        check("post_reset_rhs_ready", int'(bus.rhs_ready), 1);
        check("post_reset_busy", int'(bus.busy), 0);

        // Plain job
        t = cyc + 1;
        push_blks(1'b0, t);
        drive(t, 1, 0, 0, 0, 0);
        at_neg(t + 4);
        check("wait_lhs_ready_ns", int'(bus.lhs_ready_ns), 1);
        check("wait_lhs_rhs_ready", int'(bus.rhs_ready), 0);
        push_job(t + 5, 16, 16, 0);
        drive(t + 5, 0, 1, 0, 0, 0);
        drive(t + 8, 0, 0, 0, 0, 1);
        at_neg(t + 26);
        check("out_ready_before_drain", int'(bus.out_ready), 0);
        at_neg(t + 27);
        check("out_ready_after_drain", int'(bus.out_ready), 1);
        check("hold_no_os_ready", int'(bus.lhs_ready_os), 0);
        push_blks(1'b1, t + 30);
        drive(t + 30, 0, 0, 0, 0, 1);
        at_neg(t + 34);
        check("idle_after_send_busy", int'(bus.busy), 0);
        check("idle_after_send_rhs_ready", int'(bus.rhs_ready), 1);
        drive(t + 35, 0, 1, 0, 0, 0);
        at_neg(t + 36);
        check("idle_lhs_ignored_busy", int'(bus.busy), 0);

        // Weight-stationary job, then an accumulate job chained from HOLD
        s = t + 38;
        push_blks(1'b0, s);
        drive(s, 1, 0, 0, 0, 0);
        push_job(s + 5, 16, 16, 0);
        drive(s + 5, 0, 1, 1, 0, 0);
        at_neg(s + 27);
        check("ws_hold_out_ready", int'(bus.out_ready), 1);
        check("ws_hold_wos_ready", int'(bus.lhs_ready_wos), 1);
        drive(s + 28, 0, 1, 0, 0, 0);
        push_job(s + 29, 16, 16, 1);
        drive(s + 29, 0, 1, 1, 1, 0);
        at_neg(s + 50);
        check("os_out_ready_before_drain", int'(bus.out_ready), 0);
        at_neg(s + 51);
        check("os_out_ready_after_drain", int'(bus.out_ready), 1);
        push_blks(1'b1, s + 53);
        drive(s + 53, 0, 1, 1, 1, 1);
        at_neg(s + 57);
        check("ws_return_rhs_ready", int'(bus.rhs_ready), 0);
        check("ws_return_lhs_ready_ns", int'(bus.lhs_ready_ns), 1);
        check("ws_return_busy", int'(bus.busy), 1);
        push_job(s + 58, 16, 16, 0);
        drive(s + 58, 0, 1, 0, 0, 0);
        at_neg(s + 80);
        check("nokeep_hold_out_ready", int'(bus.out_ready), 1);
        check("nokeep_hold_os_ready", int'(bus.lhs_ready_os), 0);
        drive(s + 81, 0, 1, 0, 1, 0);
        push_blks(1'b1, s + 82);
        drive(s + 82, 0, 0, 0, 0, 1);
        at_neg(s + 86);
        check("job2_idle_busy", int'(bus.busy), 0);

        // Reset in the middle of streaming, just as row 7 would issue
        r = s + 88;
        push_blks(1'b0, r);
        drive(r, 1, 0, 0, 0, 0);
        push_job(r + 5, 7, 1, 0);
        drive(r + 5, 0, 1, 0, 0, 0);
        go_to(r + 12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_rhs_ready", int'(bus.rhs_ready), 1);
        go_to(r + 45);
        @(negedge clk);

        check("rhs_events_left", rhs_q.size(), 0);
        check("issue_events_left", iss_q.size(), 0);
        check("acc_events_left", acc_q.size(), 0);
        check("rd_events_left", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
